eth_stream_arbiter: RTL and testbench

- Downstream consumer of the per-channel AXI-snoop submodules (AW/W/AR/R/B). Each submodule exposes a valid/in_progress/last/data stream and waits on a ready.
- Arbitrates round-robin among up to NUM_SRC sources and grants exactly one source at a time for a whole packet.
- Merges the granted stream into a single AXI4-Stream master toward the Ethernet TX path, through a registered skid buffer.

---
 rtl/eth_helper_pkg.sv | 40 ++++
 rtl/eth_stream_arbiter_if.sv | 34 +++
 rtl/eth_stream_skid_buf.sv | 65 ++++++
 rtl/eth_stream_arbiter.sv | 148 ++++++++++++++
 tb/tb_eth_stream_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_helper_pkg.sv
// Shared types and helpers for the Ethernet stream arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   SKID_DEPTH  : number of entries in the output skid buffer
//   MAX_SRC     : largest supported source count (sizes rr_pick arguments)
//   rr_pick     : index of the first requester at or after ptr, modulo num_src
package eth_helper_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int SKID_DEPTH = 2;
    localparam int MAX_SRC    = 8;

    function automatic logic [2:0] rr_pick(
        input logic [MAX_SRC-1:0] req,
        input logic [2:0]         ptr,
        input int                 num_src
    );
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (i < num_src) begin
                // ptr < num_src and i < num_src, so one subtraction wraps it
                idx = int'(ptr) + i;
                if (idx >= num_src) idx = idx - num_src;
                if (!found && req[idx]) begin
                    pick  = 3'(idx);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/eth_stream_arbiter_if.sv
// Handshake bundle between the AXI-snoop source channels, the arbiter and
// the Ethernet TX AXI4-Stream sink.
//   src_valid/src_in_progress/src_last/src_data : per-source stream inputs
//   src_ready                                   : per-source grant/ready
//   m_axis_t*                                   : merged AXI4-Stream output
// Modport master is the arbiter (drives src_ready and m_axis); modport slave
// is the surrounding environment (sources plus downstream sink).
interface eth_stream_arbiter_if #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_SRC    = 5,
    parameter int DEST_WIDTH = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0]            src_valid;
    logic [NUM_SRC-1:0]            src_in_progress;
    logic [NUM_SRC-1:0]            src_last;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]            src_ready;

    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tlast;
    logic [DEST_WIDTH-1:0]         m_axis_tdest;
    logic                          m_axis_tready;

    modport master (
        input  src_valid, src_in_progress, src_last, src_data, m_axis_tready,
        output src_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest
    );

    modport slave (
        output src_valid, src_in_progress, src_last, src_data, m_axis_tready,
        input  src_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest
    );
endinterface

// File: rtl/eth_stream_skid_buf.sv
// Two-entry registered skid buffer (FIFO). Output is always taken from a
// register, so a beat written in cycle n is presented in cycle n+1.
//   clk, reset          : clock, async active-high reset
//   in_valid/in_ready   : write side; in_ready = not full
//   in_data             : {data, last, dest} word
//   out_valid/out_ready : read side
//   out_data            : head entry
module eth_stream_skid_buf
    import eth_helper_pkg::*;
#(
    parameter int WIDTH = 132
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic [WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [WIDTH-1:0] mem_d [SKID_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    assign in_ready  = (count_q != 2'(SKID_DEPTH));
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/eth_stream_arbiter.sv
// Round-robin packet arbiter merging NUM_SRC AXI-snoop channel streams into
// one AXI4-Stream toward Ethernet TX. A grant is held for a whole packet.
//   clk, reset : clock, async active-high reset
//   bus        : eth_stream_arbiter_if.master (source streams + m_axis)
//   proto_err  : sticky flag for a source dropping in_progress mid-packet
//   pkt_count, beat_count : output packet/beat counters, present only when
//                           ETH_STREAM_ARB_STATS_EN is defined
//
// state | meaning
// IDLE  | no grant; pick next requester from rr_ptr
// GRANT | grant held until the granted source's last beat is accepted
module eth_stream_arbiter
    import eth_helper_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_SRC    = 5,
    parameter int DEST_WIDTH = $clog2(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 reset,
    eth_stream_arbiter_if.master bus,
    output logic                 proto_err
`ifdef ETH_STREAM_ARB_STATS_EN
    ,
    output logic [31:0]          pkt_count,
    output logic [31:0]          beat_count
`endif
);
    localparam int SKID_W = DATA_WIDTH + 1 + DEST_WIDTH;

    arb_state_t            state_q, state_d;
    logic [DEST_WIDTH-1:0] grant_q, grant_d;
    logic [DEST_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                  started_q, started_d;
    logic                  proto_err_q, proto_err_d;

    logic                  sel_valid, sel_last, sel_in_prog;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  skid_in_ready, skid_out_valid, src_beat;
    logic [SKID_W-1:0]     skid_out_data;
    logic [DEST_WIDTH-1:0] grant_pick, rr_next;

    assign sel_valid   = bus.src_valid[grant_q];
    assign sel_last    = bus.src_last[grant_q];
    assign sel_in_prog = bus.src_in_progress[grant_q];
    assign sel_data    = bus.src_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign src_beat    = (state_q == GRANT) && sel_valid && skid_in_ready;
    assign grant_pick  = DEST_WIDTH'(rr_pick(MAX_SRC'(bus.src_valid), 3'(rr_ptr_q), NUM_SRC));
    assign rr_next     = (grant_q == DEST_WIDTH'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        bus.src_ready = '0;
        if (state_q == GRANT) bus.src_ready[grant_q] = skid_in_ready;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        started_d   = started_q;
        proto_err_d = proto_err_q;
        case (state_q)
            IDLE: begin
                if (|bus.src_valid) begin
                    grant_d   = grant_pick;
                    started_d = 1'b0;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                if (src_beat) begin
                    started_d = 1'b1;
                    if (sel_last) begin
                        rr_ptr_d = rr_next;
                        state_d  = IDLE;
                    end
                end
                // Only judged once the packet has started; the beat carrying
                // last may legitimately arrive with in_progress already low.
                if (started_q && !sel_in_prog && !(src_beat && sel_last)) proto_err_d = 1'b1;
                if (started_q && !sel_valid && !sel_in_prog) proto_err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            started_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            started_q   <= started_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;

    eth_stream_skid_buf #(.WIDTH(SKID_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (src_beat),
        .in_ready  (skid_in_ready),
        .in_data   ({sel_data, sel_last, grant_q}),
        .out_valid (skid_out_valid),
        .out_ready (bus.m_axis_tready),
        .out_data  (skid_out_data)
    );

    assign bus.m_axis_tvalid = skid_out_valid;
    assign {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tdest} = skid_out_data;

`ifdef ETH_STREAM_ARB_STATS_EN
    logic        out_xfer;
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [31:0] beat_count_q, beat_count_d;

    assign out_xfer = skid_out_valid & bus.m_axis_tready;

    always_comb begin
        pkt_count_d  = pkt_count_q;
        beat_count_d = beat_count_q;
        if (out_xfer) begin
            beat_count_d = beat_count_q + 32'd1;
            if (bus.m_axis_tlast) pkt_count_d = pkt_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count_q  <= '0;
            beat_count_q <= '0;
        end else begin
            pkt_count_q  <= pkt_count_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign beat_count = beat_count_q;
`endif
endmodule

// File: tb/tb_eth_stream_arbiter.sv
// Self-checking bench for eth_stream_arbiter. Expected output beats are
// queued per scenario in the order the arbitration rules dictate and popped
// by the output monitor as m_axis beats transfer.
module tb_eth_stream_arbiter;
    localparam int DW   = 128;
    localparam int NS   = 5;
    localparam int DSTW = 3;
    typedef logic [DW+1+DSTW-1:0] beat_t;

    logic clk = 1'b0;
    logic reset;
    logic proto_err;
`ifdef ETH_STREAM_ARB_STATS_EN
    logic [31:0] pkt_count, beat_count;
`endif

    always #5 clk = ~clk;

    eth_stream_arbiter_if #(.DATA_WIDTH(DW), .NUM_SRC(NS), .DEST_WIDTH(DSTW)) bus ();

    eth_stream_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .DEST_WIDTH(DSTW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .proto_err (proto_err)
`ifdef ETH_STREAM_ARB_STATS_EN
        ,
        .pkt_count (pkt_count),
        .beat_count(beat_count)
`endif
    );

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    bit    sb_en = 1'b1;
    beat_t exp_q[$];
    int    out_cyc[$];
    int    out_dest[$];
    int    acc_cyc[$];
    int    acc_src[$];
    int    len[NS], base[NS], idx[NS], drop_at[NS];
    int    hold_s = 0;
    int    hold_n = 0;

    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] mk_data(input int x);
        logic [31:0] w;
        w = 32'(x);
        return {~w, w, ~w, w};
    endfunction

    // Output scoreboard
    always @(negedge clk) begin
        beat_t got, want;
        if (!reset && sb_en && bus.m_axis_tvalid && bus.m_axis_tready) begin
            got = {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tdest};
            out_cyc.push_back(cyc);
            out_dest.push_back(int'(bus.m_axis_tdest));
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got=%h required=none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL sb_beat got=%h required=%h", got, want);
                end
            end
        end
    end

    task automatic clear_traffic();
        for (int i = 0; i < NS; i++) begin
            len[i] = 0; base[i] = 0; idx[i] = 0; drop_at[i] = 1000;
        end
        hold_n = 0;
        exp_q.delete(); out_cyc.delete(); out_dest.delete();
        acc_cyc.delete(); acc_src.delete();
        bus.src_valid       = '0;
        bus.src_in_progress = '0;
        bus.src_last        = '0;
        bus.src_data        = '0;
        bus.m_axis_tready   = 1'b1;
    endtask

    task automatic do_reset();
        clear_traffic();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic add_pkt(input int src, input int b, input int n);
        len[src]  = n;
        base[src] = b;
        idx[src]  = 0;
        for (int k = 0; k < n; k++)
            exp_q.push_back({mk_data(b + k), (k == n - 1), 3'(src)});
    endtask

    task automatic drive_sources();
        for (int i = 0; i < NS; i++) begin
            if (idx[i] < len[i]) begin
                bus.src_valid[i]            = 1'b1;
                bus.src_last[i]             = (idx[i] == len[i] - 1);
                bus.src_in_progress[i]      = (idx[i] < drop_at[i]);
                bus.src_data[i*DW +: DW]    = mk_data(base[i] + idx[i]);
            end else begin
                bus.src_valid[i]            = 1'b0;
                bus.src_last[i]             = 1'b0;
                bus.src_in_progress[i]      = 1'b0;
                bus.src_data[i*DW +: DW]    = '0;
            end
        end
        bus.m_axis_tready = !(hold_n > 0 && cyc >= hold_s && cyc < hold_s + hold_n);
    endtask

    task automatic run_traffic(input int budget);
        int n;
        bit busy;
        n    = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            @(posedge clk);
            #1;
            busy = (exp_q.size() != 0);
            for (int i = 0; i < NS; i++) if (idx[i] < len[i]) busy = 1'b1;
            if (busy) begin
                n++;
                drive_sources();
                @(negedge clk);
                for (int i = 0; i < NS; i++) begin
                    if (bus.src_valid[i] && bus.src_ready[i]) begin
                        idx[i]++;
                        acc_cyc.push_back(cyc);
                        acc_src.push_back(i);
                    end
                end
            end
        end
        bus.m_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        clear_traffic();
        reset = 1'b1;
        @(negedge clk);
        total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b required=0", bus.m_axis_tvalid); end
        total++; if (bus.m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b required=0", bus.m_axis_tlast); end
        total++; if (bus.m_axis_tdata !== '0) begin bad++; $display("FAIL rst_tdata got=%h required=0", bus.m_axis_tdata); end
        total++; if (bus.m_axis_tdest !== '0) begin bad++; $display("FAIL rst_tdest got=%h required=0", bus.m_axis_tdest); end
        total++; if (bus.src_ready !== '0) begin bad++; $display("FAIL rst_src_ready got=%b required=0", bus.src_ready); end
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rst_proto_err got=%b required=0", proto_err); end
`ifdef ETH_STREAM_ARB_STATS_EN
        total++; if (pkt_count !== 32'd0 || beat_count !== 32'd0) begin bad++; $display("FAIL rst_counts got=%0d/%0d required=0/0", pkt_count, beat_count); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_single_src();
        int c0;
        do_reset();
        add_pkt(2, 'hA0, 4);
        c0 = cyc + 1;
        run_traffic(100);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_left got=%0d required=0", exp_q.size()); end
        total++;
        if (out_cyc.size() != 4) begin
            bad++; $display("FAIL single_count got=%0d required=4", out_cyc.size());
        end else if (out_cyc[0] - c0 != 2) begin
            bad++; $display("FAIL single_latency got=%0d required=2", out_cyc[0] - c0);
        end
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL single_proto_err got=%b required=0", proto_err); end
        // rr_ptr is now 3: with 0 and 4 both requesting, 4 must win first
        clear_traffic();
        add_pkt(4, 'h40, 1);
        add_pkt(0, 'h10, 1);
        run_traffic(100);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rrptr_left got=%0d required=0", exp_q.size()); end
        total++;
        if (out_dest.size() != 2) begin
            bad++; $display("FAIL rrptr_count got=%0d required=2", out_dest.size());
        end else if (out_dest[0] != 4) begin
            bad++; $display("FAIL rrptr_first got=%0d required=4", out_dest[0]);
        end
    endtask

    task automatic test_simultaneous();
        int offs[6];
        int srcs[6];
        offs = '{0, 1, 3, 4, 6, 7};
        srcs = '{0, 0, 1, 1, 3, 3};
        do_reset();
        add_pkt(0, 'h100, 2);
        add_pkt(1, 'h110, 2);
        add_pkt(3, 'h130, 2);
        run_traffic(200);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL simul_left got=%0d required=0", exp_q.size()); end
        total++;
        if (acc_cyc.size() != 6 || out_cyc.size() != 6) begin
            bad++; $display("FAIL simul_count got=%0d/%0d required=6/6", acc_cyc.size(), out_cyc.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                total++;
                if (acc_src[k] != srcs[k] || acc_cyc[k] - acc_cyc[0] != offs[k] || out_cyc[k] - out_cyc[0] != offs[k]) begin
                    bad++;
                    $display("FAIL simul_timing beat=%0d got src=%0d in=%0d out=%0d required src=%0d off=%0d",
                             k, acc_src[k], acc_cyc[k] - acc_cyc[0], out_cyc[k] - out_cyc[0], srcs[k], offs[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int c0;
        int in_win;
        int out_win;
        do_reset();
        add_pkt(1, 'h200, 6);
        c0     = cyc + 1;
        hold_s = c0 + 4;
        hold_n = 5;
        fork
            run_traffic(200);
            begin
                wait (cyc == c0 + 6);
                @(negedge clk);
                total++; if (bus.src_ready !== 5'b0) begin bad++; $display("FAIL bp_ready_drop got=%b required=00000", bus.src_ready); end
                total++; if (bus.m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL bp_tvalid got=%b required=1", bus.m_axis_tvalid); end
            end
        join
        in_win  = 0;
        out_win = 0;
        foreach (acc_cyc[k]) if (acc_cyc[k] >= hold_s && acc_cyc[k] < hold_s + hold_n) in_win++;
        foreach (out_cyc[k]) if (out_cyc[k] >= hold_s && out_cyc[k] < hold_s + hold_n) out_win++;
        total++; if (in_win != 1) begin bad++; $display("FAIL bp_accepts_in_hold got=%0d required=1", in_win); end
        total++; if (out_win != 0) begin bad++; $display("FAIL bp_out_in_hold got=%0d required=0", out_win); end
        total++; if (exp_q.size() != 0 || acc_cyc.size() != 6) begin bad++; $display("FAIL bp_complete got left=%0d acc=%0d required=0/6", exp_q.size(), acc_cyc.size()); end
    endtask

    task automatic test_no_preempt();
        do_reset();
        add_pkt(0, 'h300, 10);
        add_pkt(4, 'h340, 3);
        run_traffic(200);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL nopre_left got=%0d required=0", exp_q.size()); end
        total++;
        if (acc_src.size() != 13 || out_dest.size() != 13) begin
            bad++; $display("FAIL nopre_count got=%0d/%0d required=13/13", acc_src.size(), out_dest.size());
        end else if (acc_src[9] != 0 || acc_src[10] != 4 || acc_cyc[10] - acc_cyc[9] != 2 ||
                     out_dest[9] != 0 || out_dest[10] != 4) begin
            bad++;
            $display("FAIL nopre_switch got src=%0d,%0d gap=%0d dest=%0d,%0d required src=0,4 gap=2 dest=0,4",
                     acc_src[9], acc_src[10], acc_cyc[10] - acc_cyc[9], out_dest[9], out_dest[10]);
        end
    endtask

    task automatic test_proto_err();
        do_reset();
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL perr_initial got=%b required=0", proto_err); end
        add_pkt(2, 'h400, 3);
        drop_at[2] = 1;
        run_traffic(100);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL perr_forwarded got left=%0d required=0", exp_q.size()); end
        total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL perr_set got=%b required=1", proto_err); end
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL perr_sticky got=%b required=1", proto_err); end
    endtask

    task automatic test_reset_midpacket();
        bit seen;
        do_reset();
        sb_en = 1'b0;
        @(posedge clk);
        #1;
        bus.src_valid[3]       = 1'b1;
        bus.src_in_progress[3] = 1'b1;
        bus.src_last[3]        = 1'b0;
        bus.src_data[3*DW +: DW] = mk_data('h500);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (bus.m_axis_tvalid === 1'b1) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL midrst_stream_start got=0 required=1"); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL midrst_tvalid got=%b required=0", bus.m_axis_tvalid); end
        total++; if (bus.src_ready !== 5'b0) begin bad++; $display("FAIL midrst_src_ready got=%b required=00000", bus.src_ready); end
        clear_traffic();
        @(negedge clk);
        reset = 1'b0;
        sb_en = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL midrst_after got=%b required=0", bus.m_axis_tvalid); end
    endtask

`ifdef ETH_STREAM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        add_pkt(0, 'h600, 4);
        add_pkt(1, 'h610, 4);
        add_pkt(2, 'h620, 4);
        run_traffic(200);
        @(negedge clk);
        total++; if (pkt_count !== 32'd3) begin bad++; $display("FAIL stats_pkt got=%0d required=3", pkt_count); end
        total++; if (beat_count !== 32'd12) begin bad++; $display("FAIL stats_beat got=%0d required=12", beat_count); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        clear_traffic();
        test_reset();
        test_single_src();
        test_simultaneous();
        test_backpressure();
        test_no_preempt();
        test_proto_err();
        test_reset_midpacket();
`ifdef ETH_STREAM_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end
endmodule
